// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - write-back stage: scalar RF write, serialized vector RF write, forwarding
module writeback_stage #(
    parameter int DATA_W = 32,
    parameter int VLEN   = 48,
    parameter int BEAT_W = 16,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wb_valid,
    input  logic              i_reg_write,
    input  logic              i_vreg_write,
    input  logic [1:0]        i_men2reg,
    input  logic [DATA_W-1:0] i_aluRes,
    input  logic [DATA_W-1:0] i_signImm,
    input  logic [VLEN-1:0]   i_data,
    input  logic [VLEN-1:0]   i_aluResV,
    input  logic [REG_AW-1:0] i_rd,
    input  logic [REG_AW-1:0] i_vd,
    output logic              o_stall,
    output logic              o_rf_we,
    output logic [REG_AW-1:0] o_rf_addr,
    output logic [DATA_W-1:0] o_rf_wdata,
    output logic              o_vrf_we,
    output logic [REG_AW-1:0] o_vrf_addr,
    output logic [1:0]        o_vrf_lane,
    output logic [BEAT_W-1:0] o_vrf_wdata,
    output logic              o_fwd_valid,
    output logic [REG_AW-1:0] o_fwd_rd,
    output logic [DATA_W-1:0] o_fwd_data
);

    // Beat count is fixed by the vector and port widths.
    localparam int         BEATS     = VLEN / BEAT_W;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_VBEAT = 1'b1
    } state_t;

    state_t                        r_state;
    logic [1:0]                    r_beat;
    logic [VLEN-1:0]               r_vword;
    logic [REG_AW-1:0]             r_vd;
    logic                          r_rf_we;
    logic [REG_AW-1:0]             r_rf_addr;
    logic [DATA_W-1:0]             r_rf_wdata;

    logic                          w_stall;
    logic                          w_accept;
    logic                          w_scalar_wr;
    logic                          w_vector_wr;
    logic [DATA_W-1:0]             w_scalar_sel;
    logic [VLEN-1:0]               w_vector_sel;
    logic [BEATS-1:0][BEAT_W-1:0]  w_lanes;

    // Upstream is held while lanes other than the last are still pending, so the
    // next instruction can be taken in the final beat without a bubble.
    assign w_stall     = (r_state == S_VBEAT) && (r_beat != LAST_BEAT);
    assign w_accept    = i_wb_valid && !w_stall;
    assign w_scalar_wr = w_accept && i_reg_write && (i_rd != '0);
    assign w_vector_wr = w_accept && i_vreg_write;

    // Scalar result mux; the reserved encoding falls back to the ALU result.
    always_comb begin
        w_scalar_sel = i_aluRes;
        case (i_men2reg)
            2'b01:   w_scalar_sel = i_data[DATA_W-1:0];
            2'b10:   w_scalar_sel = i_signImm;
            default: w_scalar_sel = i_aluRes;
        endcase
    end

    assign w_vector_sel = (i_men2reg == 2'b01) ? i_data : i_aluResV;

    // Scalar write port: one-cycle pulse after accept; x0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rf_we    <= 1'b0;
            r_rf_addr  <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_scalar_wr;
            if (w_scalar_wr) begin
                r_rf_addr  <= i_rd;
                r_rf_wdata <= w_scalar_sel;
            end
        end
    end

    // Vector serializer: capture word on accept, then emit one lane per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_beat  <= 2'd0;
            r_vword <= '0;
            r_vd    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_vector_wr) begin
                        r_state <= S_VBEAT;
                        r_beat  <= 2'd0;
                        r_vword <= w_vector_sel;
                        r_vd    <= i_vd;
                    end
                end
                S_VBEAT: begin
                    if (r_beat != LAST_BEAT) begin
                        r_beat <= r_beat + 2'd1;
                    end else if (w_vector_wr) begin
                        r_beat  <= 2'd0;
                        r_vword <= w_vector_sel;
                        r_vd    <= i_vd;
                    end else begin
                        r_state <= S_IDLE;
                        r_beat  <= 2'd0;
                    end
                end
            endcase
        end
    end

    assign w_lanes = r_vword;

    assign o_stall     = w_stall;
    assign o_rf_we     = r_rf_we;
    assign o_rf_addr   = r_rf_addr;
    assign o_rf_wdata  = r_rf_wdata;
    assign o_fwd_valid = r_rf_we;
    assign o_fwd_rd    = r_rf_addr;
    assign o_fwd_data  = r_rf_wdata;

    // Vector port fields are only meaningful while serializing; held at zero otherwise.
    assign o_vrf_we    = (r_state == S_VBEAT);
    assign o_vrf_addr  = o_vrf_we ? r_vd : '0;
    assign o_vrf_lane  = o_vrf_we ? r_beat : 2'd0;
    assign o_vrf_wdata = o_vrf_we ? w_lanes[r_beat] : '0;

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Write-back stage; consumes the registered outputs of the MEM/WB pipeline register.
- Drives the scalar register-file write port: 32-bit, one beat.
- Drives the vector register-file write port: 16-bit lane port, so a 48-bit vector result is serialized over 3 beats. Stalls the upstream pipeline while serializing.
- Exports forwarding information for the hazard unit.

Parameters:
- DATA_W, 32, scalar data width.
- VLEN, 48, vector register width.
- BEAT_W, 16, vector RF write-port width. BEATS = VLEN/BEAT_W (3) is derived, not overridable.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- wb_valid  in  1  MEM/WB holds a valid instruction.
- reg_write  in  1  scalar write request.
- vreg_write  in  1  vector write request.
- men2reg  in  2  source select.
- aluRes  in  DATA_W  scalar ALU result.
- signImm  in  DATA_W  sign-extended immediate.
- data  in  VLEN  memory read data.
- aluResV  in  VLEN  vector ALU result.
- rd  in  REG_AW  scalar destination.
- vd  in  REG_AW  vector destination.
- stall  out  1  upstream must hold MEM/WB.
- rf_we  out  1  scalar RF write enable.
- rf_addr  out  REG_AW  scalar RF address.
- rf_wdata  out  DATA_W  scalar RF data.
- vrf_we  out  1  vector RF write enable.
- vrf_addr  out  REG_AW  vector RF address.
- vrf_lane  out  2  lane index (0..BEATS-1).
- vrf_wdata  out  BEAT_W  lane data.
- fwd_valid  out  1  scalar result forwardable this cycle.
- fwd_rd  out  REG_AW  forwarded destination.
- fwd_data  out  DATA_W  forwarded value.

Behaviour:
- Reset: all registered outputs are 0, FSM is IDLE, beat counter is 0, captured vector is 0. Reset asserted mid-serialization aborts the transfer immediately; remaining beats are never written.
- Accept: accept = wb_valid && !stall. Inputs are sampled only on accept. While stall=1 the inputs are ignored; upstream holds them stable.
- Scalar source by men2reg:
  - 00: aluRes.
  - 01: data[DATA_W-1:0].
  - 10: signImm.
  - 11: reserved, selects aluRes.
- Scalar path: on accept with reg_write=1 and rd!=0, the cycle after accept has:
  - rf_we=1, rf_addr=rd, rf_wdata=selected value;
  - fwd_valid=1, fwd_rd=rd, fwd_data=selected value.
  - Otherwise rf_we=0 and fwd_valid=0 that cycle.
  - rd=0 is never written (x0 is hardwired).
  - Latency is 1 cycle; the port is pulsed for exactly one cycle per instruction.
- Vector source: men2reg==01 selects data; any other value selects aluResV. The selected word and vd are captured on accept.
- FSM IDLE / VBEAT:
  - IDLE: on accept with vreg_write=1, go to VBEAT, beat=0.
  - VBEAT: each cycle drive vrf_we=1, vrf_addr=captured vd, vrf_lane=beat, vrf_wdata=word[beat*BEAT_W +: BEAT_W]. Lane 0 carries bits [15:0] and is written first. beat increments.
  - On beat==BEATS-1: if an accept with vreg_write=1 occurs that same cycle, capture the new word and stay in VBEAT with beat=0 (back-to-back, no bubble). Otherwise return to IDLE.
  - vrf_we=0 in IDLE.
- stall is combinational: stall = (state==VBEAT) && (beat != BEATS-1). With BEATS=3 it is high for the first 2 beat cycles.
- Combined instruction (reg_write and vreg_write both set): the scalar write occurs in the first beat cycle, in parallel with lane 0. The vector and scalar ports are independent and may both be active in the same cycle.
- A scalar-only accept during the last vector beat is legal; its scalar write issues in the next cycle.
- wb_valid=0, or reg_write=vreg_write=0: no writes, no state change except an in-flight serialization continuing.

Test Plan:
- Reset then wb_valid=1, reg_write=1, men2reg=10, signImm=0xFFFFFFF0, rd=7 -> next cycle rf_we=1, rf_addr=7, rf_wdata=0xFFFFFFF0, fwd_valid=1; stall never asserts.
- reg_write=1, rd=0, aluRes=0x1234 -> rf_we and fwd_valid stay 0.
- vreg_write=1, men2reg=01, data=0xAAAA_BBBB_CCCC, vd=3 -> three consecutive cycles with vrf_lane 0/1/2 and vrf_wdata 0xCCCC/0xBBBB/0xAAAA, vrf_addr=3; stall=1 on the first two, 0 on the third.
- Two back-to-back vector instructions (aluResV=0x000100020003 vd=1, then 0x000400050006 vd=2) -> six contiguous vrf_we cycles, no bubble; the second instruction is accepted in the cycle of lane 2 of the first.
- Combined write (reg_write=1, vreg_write=1, men2reg=00, aluRes=0x55, rd=4, vd=9) -> first beat cycle shows rf_we=1 (rd 4, 0x55) together with vrf lane 0 for vd 9.
- rst pulsed during lane 1 of a vector transfer -> all outputs 0 asynchronously; lane 2 never issued; after release, stall=0 and FSM is IDLE.
